// File: rtl/vga_scaler_pkg.sv
// Shared types and constants for the Avalon-ST pixel replicating upscaler.
package vga_scaler_pkg;

  localparam int unsigned DATA_W_DEF = 30;
  localparam int unsigned R_W        = 10;
  localparam int unsigned G_W        = 10;
  localparam int unsigned B_W        = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Counter width for a limit n; a limit of 1 still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One-line pixel store: simple dual-port, registered read, no reset.
module line_buffer_ram
  import vga_scaler_pkg::*;
#(
  parameter  int unsigned DEPTH = 320,
  parameter  int unsigned WIDTH = DATA_W_DEF,
  localparam int unsigned AW    = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/video_upscaler_st.sv
// Integer pixel/line replicating upscaler between an Avalon-ST sink and source.
module video_upscaler_st
  import vga_scaler_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned IN_W    = 320,
  parameter int unsigned IN_H    = 240,
  parameter int unsigned SCALE_X = 2,
  parameter int unsigned SCALE_Y = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] sink_data,
  input  logic              sink_valid,
  input  logic              sink_startofpacket,
  input  logic              sink_endofpacket,
  output logic              sink_ready,
  output logic [DATA_W-1:0] source_data,
  output logic              source_valid,
  output logic              source_startofpacket,
  output logic              source_endofpacket,
  input  logic              source_ready,
  input  logic              bypass,
  output logic              frame_err
);

  localparam int unsigned COL_W = cnt_w(IN_W);
  localparam int unsigned ROW_W = cnt_w(IN_H);
  localparam int unsigned RX_W  = cnt_w(SCALE_X);
  localparam int unsigned RY_W  = cnt_w(SCALE_Y);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, fetch_q, fetch_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [RX_W-1:0]   rep_x_q, rep_x_d;
  logic [RY_W-1:0]   rep_y_q, rep_y_d;
  logic              bypass_q, bypass_d;
  logic              valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic              eop_px_q, eop_px_d, err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d, rd_data;

  logic        byp_eff, last_rep_x, consume, advance, row_done;
  logic        last_row, last_col, last_pass, accept, start, fill_acc;
  int unsigned sx_eff, sy_eff;

  // Bypass is sampled live only on the SOP beat that starts a frame.
  assign byp_eff    = (state_q == ST_IDLE) ? bypass : bypass_q;
  assign sx_eff     = byp_eff ? 32'd1 : SCALE_X;
  assign sy_eff     = byp_eff ? 32'd1 : SCALE_Y;
  assign last_rep_x = (32'(rep_x_q) == sx_eff - 32'd1);
  assign consume    = valid_q & source_ready & last_rep_x;
  assign advance    = valid_q & source_ready & ~last_rep_x;
  // Column counter wraps after the last pixel is accepted, so a full line shows as col 0 with data held.
  assign row_done   = (state_q == ST_FILL) & valid_q & (col_q == '0);
  assign last_row   = (32'(row_q) == IN_H - 32'd1);
  assign last_col   = (32'(col_q) == IN_W - 32'd1);
  assign last_pass  = (32'(rep_y_q) == sy_eff - 32'd2);
  assign accept     = sink_valid & sink_ready;
  assign start      = (state_q == ST_IDLE) & accept & sink_startofpacket;
  assign fill_acc   = (state_q == ST_FILL) & accept;

  line_buffer_ram #(
    .DEPTH (IN_W),
    .WIDTH (DATA_W)
  ) u_line_buf (
    .clk_i   (clk_clk),
    .we_i    (start | fill_acc),
    .waddr_i (col_q),
    .wdata_i (sink_data),
    .raddr_i (fetch_d),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_FILL;
      ST_FILL:   if (consume && row_done) begin
                   if (sy_eff > 32'd1) state_d = ST_REPEAT;
                   else if (last_row)  state_d = ST_IDLE;
                 end
      ST_REPEAT: if (consume && last_col && last_pass)
                   state_d = last_row ? ST_IDLE : ST_FILL;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sink_ready = 1'b0;
    state_dp_defaults();
    if (reset_reset_n) begin
      unique case (state_q)
        ST_IDLE: sink_ready = 1'b1;
        ST_FILL: sink_ready = (~valid_q | consume) & ~row_done;
        default: sink_ready = 1'b0;
      endcase
    end

    if (advance) begin
      rep_x_d = rep_x_q + RX_W'(1);
      sop_d   = 1'b0;
      eop_d   = eop_px_q & (32'(rep_x_q) + 32'd1 == sx_eff - 32'd1);
    end else if (consume) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      rep_x_d = '0;
    end

    if (start || fill_acc) begin
      valid_d  = 1'b1;
      data_d   = sink_data;
      sop_d    = start;
      rep_x_d  = '0;
      eop_px_d = last_row & last_col & (sy_eff == 32'd1);
      eop_d    = last_row & last_col & (sy_eff == 32'd1) & (sx_eff == 32'd1);
      col_d    = last_col ? '0 : col_q + COL_W'(1);
      err_d    = (sink_endofpacket != (last_row & last_col)) | (fill_acc & sink_startofpacket);
      if (start) bypass_d = bypass;
    end

    // End of a freshly filled line: start replay from column 0, or move to the next row.
    if (state_q == ST_FILL && consume && row_done) begin
      if (sy_eff > 32'd1) begin
        valid_d  = 1'b1;
        data_d   = (IN_W == 1) ? data_q : rd_data;
        rep_y_d  = '0;
        fetch_d  = (IN_W == 1) ? '0 : COL_W'(1);
        eop_px_d = last_row & (IN_W == 1) & (sy_eff == 32'd2);
        eop_d    = last_row & (IN_W == 1) & (sy_eff == 32'd2) & (sx_eff == 32'd1);
      end else begin
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end
    end

    // Replay: rd_data always holds the column after the one being presented.
    if (state_q == ST_REPEAT && consume) begin
      col_d = last_col ? '0 : col_q + COL_W'(1);
      if (last_col && last_pass) begin
        rep_y_d = '0;
        row_d   = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        valid_d  = 1'b1;
        data_d   = rd_data;
        rep_y_d  = last_col ? rep_y_q + RY_W'(1) : rep_y_q;
        fetch_d  = (32'(fetch_q) == IN_W - 32'd1) ? '0 : fetch_q + COL_W'(1);
        eop_px_d = last_row & (32'(col_d) == IN_W - 32'd1) & (32'(rep_y_d) == sy_eff - 32'd2);
        eop_d    = eop_px_d & (sx_eff == 32'd1);
      end
    end
  end

  function automatic void state_dp_defaults();
    col_d    = col_q;
    fetch_d  = fetch_q;
    row_d    = row_q;
    rep_x_d  = rep_x_q;
    rep_y_d  = rep_y_q;
    bypass_d = bypass_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    eop_px_d = eop_px_q;
    data_d   = data_q;
    err_d    = 1'b0;
  endfunction

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      col_q    <= '0;
      fetch_q  <= '0;
      row_q    <= '0;
      rep_x_q  <= '0;
      rep_y_q  <= '0;
      bypass_q <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      eop_px_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      fetch_q  <= fetch_d;
      row_q    <= row_d;
      rep_x_q  <= rep_x_d;
      rep_y_q  <= rep_y_d;
      bypass_q <= bypass_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      eop_px_q <= eop_px_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign source_data          = data_q;
  assign source_valid         = valid_q;
  assign source_startofpacket = sop_q;
  assign source_endofpacket   = eop_q;
  assign frame_err            = err_q;

endmodule

// File: doc/video_upscaler_st.md
VIDEO_UPSCALER_ST -- requirements
Module: video_upscaler_st

Interface
REQ-001 SHALL have parameter DATA_W, default 30, pixel width (RGB 10:10:10).
REQ-002 SHALL have parameter IN_W, default 320, input pixels per line.
REQ-003 SHALL have parameter IN_H, default 240, input lines per frame.
REQ-004 SHALL have parameters SCALE_X and SCALE_Y, default 2 each, integer replication factors, legal range 1..8.
REQ-005 SHALL have port clk_clk, input, 1, sole clock; all logic is rising-edge.
REQ-006 SHALL have port reset_reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have ports sink_data, sink_valid, sink_startofpacket and sink_endofpacket as inputs (widths DATA_W, 1, 1, 1), and sink_ready as a 1-bit output; together these form the Avalon-ST sink, ready latency 0.
REQ-008 SHALL have ports source_data, source_valid, source_startofpacket and source_endofpacket as outputs (widths DATA_W, 1, 1, 1), and source_ready as a 1-bit input; together these form the Avalon-ST source, ready latency 0.
REQ-009 SHALL have port bypass, input, 1, 1 = pass frame unscaled (1x1).
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on an input framing mismatch.

Function
REQ-011 SHALL implement states IDLE, FILL, REPEAT.
REQ-012 In IDLE, SHALL hold sink_ready=1 and discard accepted beats with sink_startofpacket=0.
REQ-013 On an accepted SOP beat in IDLE, SHALL latch bypass for the whole frame, treat the beat as pixel (0,0), and enter FILL.
REQ-014 In FILL, SHALL write each accepted pixel to line buffer[col] and emit it SCALE_X times consecutively (1 time if bypass).
REQ-015 In FILL, sink_ready SHALL be 1 only when the output register is empty, or is presenting the final replica and source_ready=1; the combinational path source_ready->sink_ready is permitted.
REQ-016 On completion of the last replica of col IN_W-1 in FILL, SHALL enter REPEAT if effective SCALE_Y>1; otherwise SHALL enter FILL for the next row, or IDLE after row IN_H-1.
REQ-017 In REPEAT, SHALL hold sink_ready=0 and replay the buffered line SCALE_Y-1 times, each pixel SCALE_X times, then enter FILL for the next row, or IDLE after row IN_H-1.
REQ-018 source_valid SHALL remain asserted with data, SOP and EOP stable until source_ready=1.
REQ-019 With source_ready held at 1, SHALL produce one beat per cycle in REPEAT with no bubbles; line-buffer read latency SHALL be hidden by prefetch.
REQ-020 First output beat SHALL be valid the cycle after the input SOP beat is accepted.
REQ-021 source_startofpacket SHALL be 1 only on output beat 0; source_endofpacket SHALL be 1 only on beat IN_W*SCALE_X*IN_H*SCALE_Y-1 (IN_W*IN_H-1 in bypass).
REQ-022 Framing SHALL be counter-based; an input EOP not on pixel IN_W*IN_H-1, a missing EOP on that pixel, or an SOP mid-frame SHALL pulse frame_err for 1 cycle while the beat is processed as an ordinary pixel.
REQ-023 Col/row/replica counters SHALL be sized with $clog2 of their limits and SHALL wrap to 0 at end of frame.
REQ-024 A change of bypass mid-frame SHALL have no effect until the next IDLE->FILL transition.

Reset
REQ-025 While reset_reset_n=0, SHALL force state=IDLE, all counters=0, source_valid=0, source_startofpacket=0, source_endofpacket=0, source_data=0, frame_err=0, sink_ready=0.
REQ-026 On reset assertion mid-frame, SHALL abandon the frame; line-buffer contents are don't-care; first cycle after release SHALL be IDLE with sink_ready=1.

Structure
REQ-027 Package vga_scaler_pkg SHALL hold the state enum, DATA_W default, and RGB field width constants (10/10/10).
REQ-028 Sub-module line_buffer_ram SHALL be a simple dual-port RAM, IN_W x DATA_W, 1-cycle synchronous read, no reset.

Verification
REQ-029 IN_W=4, IN_H=2, 2x2, source_ready=1, pixels 1..8 -> 32 beats: 1,1,2,2,3,3,4,4 twice, then 5,5,...,8,8 twice; SOP on beat 0, EOP on beat 31.
REQ-030 Same frame with bypass=1 -> 8 beats 1..8, SOP on beat 0, EOP on beat 7, no frame_err.
REQ-031 Same frame, source_ready toggled with a random 50% duty -> identical 32-beat sequence, no drops, data held stable while stalled.
REQ-032 EOP on input pixel 3 -> frame_err pulses once; output is still 32 beats with EOP only on beat 31.
REQ-033 Reset pulsed after 10 output beats, then a clean frame -> outputs zero during reset, next frame correct from beat 0.
REQ-034 Three beats without SOP while IDLE -> all accepted and discarded, no source_valid.
